// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: small FIFO in front of a UART transmitter.
// Words written by the producer are queued. Each word is presented on tx_data
// with a one-cycle tx_load strobe. tx_enable is held for the whole frame, and
// a short low gap follows so the UART returns to IDLE before the next word.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for a queued word; tx_enable low
// LOAD  | head word latched on tx_data; tx_load/tx_enable strobe next edge
// SEND  | frame in flight; tx_enable held for FRAME_CYCLES cycles
// GAP   | tx_enable low for GAP_CYCLES cycles before the next word
//
// tx_enable and tx_load are registered from the current state, so they lag
// the state by one cycle. A word accepted into an empty FIFO therefore
// appears on tx_load two edges after the write.

module uart_tx_feeder #(
    parameter int DATA_W       = 9,
    parameter int DEPTH        = 4,
    parameter int FRAME_CYCLES = 14,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                     txclk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic                     clr_ovf,
    output logic                     tx_enable,
    output logic                     tx_load,
    output logic [DATA_W-1:0]        tx_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     ovf
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        SEND = 2'b10,
        GAP  = 2'b11
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               en_d;
    logic               load_d;
    logic               pop;
    logic               push;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Full check looks only at the stored level, so a write is refused while
    // full even when the FSM pops on the same edge.
    assign wr_ready = (level < LVL_FULL);
    assign push     = wr_valid && wr_ready;
    assign busy     = (state_q != IDLE) || (level != '0);

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge txclk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Sticky overflow flag; a new overflow wins over a clear on the same edge.
    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (wr_valid && !wr_ready) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    // FSM state and cycle counter register.
    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and next-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        load_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (level != '0) begin
                    state_d = LOAD;
                    pop     = 1'b1;
                end
            end
            LOAD: begin
                en_d    = 1'b1;
                load_d  = 1'b1;
                cnt_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                en_d = 1'b1;
                if (cnt_q == FRAME_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered UART controls; tx_data only changes on the pop edge.
    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            tx_enable <= 1'b0;
            tx_load   <= 1'b0;
            tx_data   <= '0;
        end else begin
            tx_enable <= en_d;
            tx_load   <= load_d;
            if (pop) begin
                tx_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 9: width of one transmit word, matching the UART TX data width.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries; power of two, 2..16.
REQ-003 SHALL have parameter FRAME_CYCLES, default 14: txclk cycles tx_enable is held after the load cycle, covering one full UART frame.
REQ-004 SHALL have parameter GAP_CYCLES, default 2: txclk cycles tx_enable is held low between frames so the UART TX returns to IDLE.
REQ-005 SHALL have port txclk  input  1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-007 SHALL have port wr_valid  input  1: producer offers wr_data this cycle.
REQ-008 SHALL have port wr_data  input  DATA_W: word to transmit.
REQ-009 SHALL have port wr_ready  output  1: FIFO can accept a word; high iff level < DEPTH (combinational from level).
REQ-010 SHALL have port clr_ovf  input  1: synchronous clear of ovf.
REQ-011 SHALL have port tx_enable  output  1: registered; drives the UART TX tx_enable.
REQ-012 SHALL have port tx_load  output  1: registered one-cycle strobe; drives the UART TX tx_load.
REQ-013 SHALL have port tx_data  output  DATA_W: registered; drives the UART TX tx_data; stable while tx_enable is high.
REQ-014 SHALL have port level  output  clog2(DEPTH)+1: number of words stored.
REQ-015 SHALL have port busy  output  1: high iff state != IDLE or level != 0.
REQ-016 SHALL have port ovf  output  1: sticky; set by a write attempt while full.

Function
REQ-017 SHALL accept a write on a txclk edge where wr_valid=1 and wr_ready=1, storing wr_data at the write pointer.
REQ-018 SHALL ignore a write attempt while wr_valid=1 and wr_ready=0, leave the FIFO contents unchanged, and set ovf=1 on that edge.
REQ-019 SHALL clear ovf when clr_ovf=1; if clr_ovf and a new overflow occur on the same edge, ovf SHALL be 1.
REQ-020 SHALL keep level unchanged when a write and a pop occur on the same edge; a write SHALL NOT be accepted while full, even if a pop occurs on that edge.
REQ-021 SHALL wrap both the read and write pointers modulo DEPTH; data order SHALL be strict FIFO.
REQ-022 SHALL implement FSM states IDLE, LOAD, SEND and GAP.
REQ-023 IDLE: tx_enable=0, tx_load=0; on an edge with level!=0 -> LOAD, tx_data <= head word, pop one entry.
REQ-024 LOAD (1 cycle): tx_enable=1, tx_load=1 -> SEND; clear the cycle counter.
REQ-025 SEND: tx_enable=1, tx_load=0, tx_data held; after FRAME_CYCLES cycles -> GAP; clear the counter.
REQ-026 GAP: tx_enable=0, tx_data held; after GAP_CYCLES cycles -> IDLE.
REQ-027 SHALL produce these outputs: tx_load high exactly 1 cycle per word; tx_enable high 1+FRAME_CYCLES consecutive cycles per word.
REQ-028 SHALL use a cycle counter wide enough for max(FRAME_CYCLES, GAP_CYCLES); it SHALL never wrap within a state.
REQ-029 SHALL meet this latency: a write accepted into an empty FIFO at edge N while in IDLE -> tx_load=1 and tx_enable=1 after edge N+2.
REQ-030 SHALL meet this throughput: back-to-back words start every 2+FRAME_CYCLES+GAP_CYCLES cycles, 18 with defaults.
REQ-031 SHALL keep writes accepted during LOAD, SEND and GAP; they SHALL NOT disturb tx_data.
REQ-032 SHALL recover to IDLE on the next edge from any illegal state encoding, with tx_enable=0.

Reset
REQ-033 SHALL, while reset=0 and regardless of txclk, force: state=IDLE, tx_enable=0, tx_load=0, tx_data=0, level=0, pointers=0, ovf=0, counter=0.
REQ-034 SHALL discard any in-flight word and all FIFO contents on reset asserted mid-frame; tx_enable SHALL fall without waiting for a clock.
REQ-035 SHALL give wr_ready=1 and busy=0 during reset and on the first edge after reset release.

Verification
REQ-036 SHALL cover single word: write 9'h1A5 into an idle feeder -> tx_load pulse 2 edges later with tx_data=9'h1A5; tx_enable high 15 cycles, then low 2 cycles; busy=0 afterwards.
REQ-037 SHALL cover burst: write 9'h001, 9'h0FF, 9'h155, 9'h1AA back-to-back -> all accepted; transmitted in order; tx_load pulses 18 cycles apart.
REQ-038 SHALL cover overflow: with a frame in SEND, fill to level=4, then write 9'h077 -> wr_ready=0, word dropped, ovf=1; clr_ovf -> ovf=0; data order intact.
REQ-039 SHALL cover same-edge push/pop: level=1 in IDLE with a write on the pop edge -> level stays 1; both words transmitted in order.
REQ-040 SHALL cover reset mid-SEND: assert reset=0 at cycle 5 of SEND -> tx_enable=0 immediately, level=0, tx_data=0; after release, no frame starts without a new write.
REQ-041 SHALL cover pointer wrap: write and transmit 10 words sequentially -> output sequence equals input sequence; level returns to 0.
